mem_arbiter: RTL and testbench

- Shares the single external memory bus between the fetch stage (instr_addr/instr_data/instr_busy) and the memory stage (load/store).
- Holds a one-entry fetch buffer, so a stalled fetch that re-presents the same PC completes without a bus access.
- Sequences bus transactions with a small FSM. Data requests take priority, because they belong to the older instruction.

---
 rtl/mem_arbiter_pkg.sv | 11 +
 rtl/mem_arbiter_if.sv | 12 +
 rtl/mem_arbiter_fetch_buf.sv | 35 +++
 rtl/mem_arbiter.sv | 80 ++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// br32_mem_pkg: shared types and constants for the fetch/data memory arbiter.
package br32_mem_pkg;
  typedef enum logic [1:0] {IDLE, IBUS, DBUS} arb_state_t;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: external single-master memory bus with a one-cycle ack pulse.
interface mem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
  modport slave (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/mem_arbiter_fetch_buf.sv
// fetch_buf: one-entry instruction word buffer with fill, store invalidate and hit compare.
module fetch_buf #(
  parameter bit EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fill,
  input  logic [31:2] fill_addr,
  input  logic [31:0] fill_data,
  input  logic        inv,
  input  logic [31:2] inv_addr,
  input  logic [31:2] lookup_addr,
  output logic        hit,
  output logic [31:0] data
);
  logic        valid;
  logic [31:2] addr;
  logic        inv_hit;
  // A store hitting the buffered word already hides it in its ack cycle.
  assign inv_hit = inv && valid && inv_addr == addr;
  assign hit = valid && addr == lookup_addr && !inv_hit;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (inv_hit) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= EN;
      addr  <= fill_addr;
      data  <= fill_data;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction fetch and load/store,
// with a one-entry fetch buffer and ack-cycle re-arbitration for back-to-back requests.
module mem_arbiter
  import br32_mem_pkg::*;
#(
  parameter bit DATA_PRIO = 1'b1,
  parameter bit FBUF_EN   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instr_addr,
  output logic [31:0]   instr_data,
  output logic          instr_busy,
  input  logic [31:0]   data_addr,
  input  logic          data_re,
  input  logic          data_we,
  input  logic [31:0]   data_wdata,
  input  logic [3:0]    data_wstrb,
  output logic [31:0]   data_rdata,
  output logic          data_busy,
  mem_arbiter_if.master bus
);
  arb_state_t  state, nxt;
  bus_req_t    cur, nxt_req;
  logic [31:2] req_addr;
  logic        dreq, ack, d_done, i_done, bypass, buf_hit, instr_hit;
  logic        go, d_pend, imiss, pick_d;
  logic [31:0] buf_data;
  assign dreq   = data_re | data_we;
  assign ack    = state != IDLE && bus.ack;
  assign d_done = state == DBUS && ack;
  assign i_done = state == IBUS && ack;
  fetch_buf #(.EN(FBUF_EN)) u_fetch_buf (
    .clk        (clk),
    .rst        (rst),
    .fill       (i_done),
    .fill_addr  (req_addr),
    .fill_data  (bus.rdata),
    .inv        (d_done && cur.we),
    .inv_addr   (cur.addr[31:2]),
    .lookup_addr(instr_addr[31:2]),
    .hit        (buf_hit),
    .data       (buf_data)
  );
  assign bypass     = i_done && req_addr == instr_addr[31:2];
  assign instr_hit  = bypass || buf_hit;
  assign instr_busy = !instr_hit;
  assign instr_data = bypass ? bus.rdata : buf_data;
  assign data_busy  = dreq && !d_done;
  assign data_rdata = bus.rdata;
  // The data request completing this cycle is dropped by its requester next cycle.
  assign go     = state == IDLE || ack;
  assign d_pend = dreq && !d_done;
  assign imiss  = !instr_hit;
  assign pick_d = d_pend && (DATA_PRIO || !imiss);
  always_comb begin
    nxt = state;
    if (go) nxt = pick_d ? DBUS : imiss ? IBUS : IDLE;
    nxt_req.we    = pick_d && data_we;
    nxt_req.addr  = (pick_d ? data_addr : instr_addr) & WORD_MASK;
    nxt_req.wdata = pick_d ? data_wdata : 32'd0;
    nxt_req.wstrb = (pick_d && data_we) ? data_wstrb : 4'hF;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= '0;
      req_addr <= '0;
    end else begin
      state <= nxt;
      if (go && nxt != IDLE) cur <= nxt_req;
      if (go && nxt == IBUS) req_addr <= instr_addr[31:2];
    end
  end
  assign bus.req   = state != IDLE;
  assign bus.we    = cur.we;
  assign bus.addr  = cur.addr;
  assign bus.wdata = cur.wdata;
  assign bus.wstrb = cur.wstrb;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; expected bus transactions are queued at stimulus and popped on ack.
module tb_mem_arbiter;
  import br32_mem_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr_addr = '0;
  logic [31:0] instr_data;
  logic        instr_busy;
  logic [31:0] data_addr = '0;
  logic        data_re = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_rdata;
  logic        data_busy;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bus_req_t    exp_q[$];
  bus_req_t    mon_e;
  mem_arbiter_if bus();
  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .instr_addr(instr_addr),
    .instr_data(instr_data),
    .instr_busy(instr_busy),
    .data_addr (data_addr),
    .data_re   (data_re),
    .data_we   (data_we),
    .data_wdata(data_wdata),
    .data_wstrb(data_wstrb),
    .data_rdata(data_rdata),
    .data_busy (data_busy),
    .bus       (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void push(logic [31:0] a, logic we, logic [3:0] s);
    exp_q.push_back('{we: we, addr: a, wdata: 32'd0, wstrb: s});
  endfunction
  always begin
    @(negedge clk);
    #2;
    if (bus.req && bus.ack) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL txn: unexpected addr=%h we=%b", bus.addr, bus.we);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.addr !== mon_e.addr || bus.we !== mon_e.we || bus.wstrb !== mon_e.wstrb) begin
          bad++;
          $display("FAIL txn: got addr=%h we=%b wstrb=%h want addr=%h we=%b wstrb=%h",
                   bus.addr, bus.we, bus.wstrb, mon_e.addr, mon_e.we, mon_e.wstrb);
        end
      end
    end
  end
  task automatic test_reset;
    bus.ack = 1'b0;
    bus.rdata = '0;
    #1 rst = 1'b1;
    #1;
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.req); end
    total++; if (bus.we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", bus.we); end
    total++; if (bus.addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", bus.addr); end
    total++; if (bus.wstrb !== 4'h0) begin bad++; $display("FAIL rst_wstrb: got %h want 0", bus.wstrb); end
    total++; if (instr_busy !== 1'b1) begin bad++; $display("FAIL rst_ibusy: got %b want 1", instr_busy); end
    total++; if (data_busy !== 1'b0) begin bad++; $display("FAIL rst_dbusy: got %b want 0", data_busy); end
  endtask
  task automatic test_cold_fetch;
    @(negedge clk); rst = 1'b0; instr_addr = 32'h100; push(32'h100, 1'b0, 4'hF); #1;
    total++; if (instr_busy !== 1'b1) begin bad++; $display("FAIL cold_busy0: got %b want 1", instr_busy); end
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL cold_req0: got %b want 0", bus.req); end
    @(negedge clk); #1;
    total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL cold_req1: got %b want 1", bus.req); end
    total++; if (bus.addr !== 32'h100) begin bad++; $display("FAIL cold_addr: got %h want 100", bus.addr); end
    @(negedge clk); #1;
    total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL cold_hold: got %b want 1", bus.req); end
    @(negedge clk); bus.ack = 1'b1; bus.rdata = 32'hDEADBEEF; #1;
    total++; if (instr_busy !== 1'b0) begin bad++; $display("FAIL cold_ack_busy: got %b want 0", instr_busy); end
    total++; if (instr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL cold_ack_data: got %h want deadbeef", instr_data); end
    @(negedge clk); bus.ack = 1'b0; bus.rdata = '0; #1;
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL cold_hit_req: got %b want 0", bus.req); end
    total++; if (instr_busy !== 1'b0) begin bad++; $display("FAIL cold_hit_busy: got %b want 0", instr_busy); end
    total++; if (instr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL cold_hit_data: got %h want deadbeef", instr_data); end
  endtask
  task automatic test_collision;
    @(negedge clk); data_re = 1'b1; data_addr = 32'h2004; instr_addr = 32'h108;
    push(32'h2004, 1'b0, 4'hF); push(32'h108, 1'b0, 4'hF); #1;
    total++; if (data_busy !== 1'b1) begin bad++; $display("FAIL col_dbusy: got %b want 1", data_busy); end
    total++; if (instr_busy !== 1'b1) begin bad++; $display("FAIL col_ibusy: got %b want 1", instr_busy); end
    @(negedge clk); bus.ack = 1'b1; bus.rdata = 32'h12345678; #1;
    total++; if (bus.addr !== 32'h2004) begin bad++; $display("FAIL col_daddr: got %h want 2004", bus.addr); end
    total++; if (data_busy !== 1'b0) begin bad++; $display("FAIL col_ddone: got %b want 0", data_busy); end
    total++; if (data_rdata !== 32'h12345678) begin bad++; $display("FAIL col_rdata: got %h want 12345678", data_rdata); end
    @(negedge clk); data_re = 1'b0; bus.ack = 1'b0; #1;
    total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL col_b2b_req: got %b want 1", bus.req); end
    total++; if (bus.addr !== 32'h108) begin bad++; $display("FAIL col_iaddr: got %h want 108", bus.addr); end
    @(negedge clk); bus.ack = 1'b1; bus.rdata = 32'hCAFE0108; #1;
    total++; if (instr_busy !== 1'b0) begin bad++; $display("FAIL col_ibusy_ack: got %b want 0", instr_busy); end
    total++; if (instr_data !== 32'hCAFE0108) begin bad++; $display("FAIL col_idata: got %h want cafe0108", instr_data); end
    @(negedge clk); bus.ack = 1'b0; #1;
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL col_idle: got %b want 0", bus.req); end
  endtask
  task automatic test_branch;
    @(negedge clk); instr_addr = 32'h10C; push(32'h10C, 1'b0, 4'hF); #1;
    total++; if (instr_busy !== 1'b1) begin bad++; $display("FAIL br_busy0: got %b want 1", instr_busy); end
    @(negedge clk); instr_addr = 32'h400; push(32'h400, 1'b0, 4'hF); #1;
    total++; if (bus.addr !== 32'h10C) begin bad++; $display("FAIL br_addr0: got %h want 10c", bus.addr); end
    total++; if (instr_busy !== 1'b1) begin bad++; $display("FAIL br_busy1: got %b want 1", instr_busy); end
    @(negedge clk); bus.ack = 1'b1; bus.rdata = 32'hB0B0010C; #1;
    total++; if (instr_busy !== 1'b1) begin bad++; $display("FAIL br_busy_ack: got %b want 1", instr_busy); end
    @(negedge clk); bus.ack = 1'b0; instr_addr = 32'h10C; #1;
    total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL br_req: got %b want 1", bus.req); end
    total++; if (bus.addr !== 32'h400) begin bad++; $display("FAIL br_addr1: got %h want 400", bus.addr); end
    total++; if (instr_busy !== 1'b0) begin bad++; $display("FAIL br_buf_busy: got %b want 0", instr_busy); end
    total++; if (instr_data !== 32'hB0B0010C) begin bad++; $display("FAIL br_buf_data: got %h want b0b0010c", instr_data); end
    @(negedge clk); instr_addr = 32'h400; bus.ack = 1'b1; bus.rdata = 32'hB0B00400; #1;
    total++; if (instr_data !== 32'hB0B00400) begin bad++; $display("FAIL br_new_data: got %h want b0b00400", instr_data); end
    @(negedge clk); bus.ack = 1'b0; #1;
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL br_idle: got %b want 0", bus.req); end
  endtask
  task automatic test_store;
    @(negedge clk); instr_addr = 32'h100; push(32'h100, 1'b0, 4'hF); #1;
    total++; if (instr_busy !== 1'b1) begin bad++; $display("FAIL st_miss: got %b want 1", instr_busy); end
    @(negedge clk); bus.ack = 1'b1; bus.rdata = 32'h11110100; #1;
    @(negedge clk); bus.ack = 1'b0; data_we = 1'b1; data_addr = 32'h102;
    data_wdata = 32'h00AB0000; data_wstrb = 4'b0100; push(32'h100, 1'b1, 4'b0100); #1;
    total++; if (instr_busy !== 1'b0) begin bad++; $display("FAIL st_buf_hit: got %b want 0", instr_busy); end
    total++; if (data_busy !== 1'b1) begin bad++; $display("FAIL st_dbusy: got %b want 1", data_busy); end
    @(negedge clk); bus.ack = 1'b1; push(32'h100, 1'b0, 4'hF); #1;
    total++; if (bus.wstrb !== 4'b0100) begin bad++; $display("FAIL st_wstrb: got %h want 4", bus.wstrb); end
    total++; if (bus.wdata !== 32'h00AB0000) begin bad++; $display("FAIL st_wdata: got %h want 00ab0000", bus.wdata); end
    total++; if (data_busy !== 1'b0) begin bad++; $display("FAIL st_done: got %b want 0", data_busy); end
    total++; if (instr_busy !== 1'b1) begin bad++; $display("FAIL st_inv: got %b want 1", instr_busy); end
    @(negedge clk); bus.ack = 1'b0; data_we = 1'b0; #1;
    total++; if (bus.req !== 1'b1 || bus.addr !== 32'h100) begin bad++; $display("FAIL st_refetch: got req=%b addr=%h want 1/100", bus.req, bus.addr); end
    @(negedge clk); bus.ack = 1'b1; bus.rdata = 32'h22220100; #1;
    total++; if (instr_data !== 32'h22220100) begin bad++; $display("FAIL st_newword: got %h want 22220100", instr_data); end
    @(negedge clk); bus.ack = 1'b0; #1;
  endtask
  task automatic test_async_reset;
    @(negedge clk); data_re = 1'b1; data_addr = 32'h3000; push(32'h3000, 1'b0, 4'hF); #1;
    total++; if (data_busy !== 1'b1) begin bad++; $display("FAIL ar_dbusy: got %b want 1", data_busy); end
    @(negedge clk); #1;
    total++; if (bus.req !== 1'b1 || bus.addr !== 32'h3000) begin bad++; $display("FAIL ar_issue: got req=%b addr=%h want 1/3000", bus.req, bus.addr); end
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL ar_req: got %b want 0", bus.req); end
    total++; if (bus.addr !== 32'h0) begin bad++; $display("FAIL ar_addr: got %h want 0", bus.addr); end
    total++; if (instr_busy !== 1'b1) begin bad++; $display("FAIL ar_buf: got %b want 1", instr_busy); end
    @(negedge clk); rst = 1'b0; data_re = 1'b0; push(32'h100, 1'b0, 4'hF); #1;
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL ar_idle: got %b want 0", bus.req); end
    @(negedge clk); #1;
    total++; if (bus.req !== 1'b1 || bus.addr !== 32'h100) begin bad++; $display("FAIL ar_refetch: got req=%b addr=%h want 1/100", bus.req, bus.addr); end
    @(negedge clk); bus.ack = 1'b1; bus.rdata = 32'h33330100; #1;
    total++; if (instr_busy !== 1'b0) begin bad++; $display("FAIL ar_fetch_busy: got %b want 0", instr_busy); end
    @(negedge clk); bus.ack = 1'b0; #1;
  endtask
  task automatic test_zero_wait;
    int start;
    logic [31:0] a;
    start = 0;
    for (int i = 0; i < 8; i++) begin
      a = 32'h200 + 32'(4 * i);
      @(negedge clk); bus.ack = 1'b0; instr_addr = a; push(a, 1'b0, 4'hF); #1;
      if (i == 0) start = cyc;
      total++; if (instr_busy !== 1'b1 || bus.req !== 1'b0) begin bad++; $display("FAIL zw_miss%0d: got busy=%b req=%b want 1/0", i, instr_busy, bus.req); end
      @(negedge clk); bus.ack = 1'b1; bus.rdata = a ^ 32'h5A5A0000; #1;
      total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL zw_req%0d: got %b want 1", i, bus.req); end
      total++; if (instr_busy !== 1'b0 || instr_data !== (a ^ 32'h5A5A0000)) begin bad++; $display("FAIL zw_data%0d: got busy=%b data=%h want 0/%h", i, instr_busy, instr_data, a ^ 32'h5A5A0000); end
    end
    @(negedge clk); bus.ack = 1'b0; #1;
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL zw_idle: got %b want 0", bus.req); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL zw_queue: got %0d left want 0", exp_q.size()); end
    total++; if (cyc - start != 16) begin bad++; $display("FAIL zw_cycles: got %0d want 16", cyc - start); end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset;
    test_cold_fetch;
    test_collision;
    test_branch;
    test_store;
    test_async_reset;
    test_zero_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
